// File: rtl/sync_fifo_flagged.sv
// Single-clock parametrised FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, sticky overflow/underflow flags and a read-valid strobe.
module sync_fifo_flagged #(
  parameter int unsigned FIFO_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AF_TH      = FIFO_DEPTH - 2,
  parameter int unsigned AE_TH      = 2,
  parameter int unsigned CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic                  err_clr,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [CW-1:0]         fill_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [CW-1:0]         count_nxt;
  logic                  wa;
  logic                  ra;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Status flags decode the count register directly, so they never lag it.
  assign empty        = (fill_count == '0);
  assign full         = (fill_count == CW'(FIFO_DEPTH));
  assign almost_empty = (fill_count <= CW'(AE_TH));
  assign almost_full  = (fill_count >= CW'(AF_TH));

  // A read frees a slot, so a write to a full FIFO is accepted alongside it.
  assign ra = r_en & ~empty;
  assign wa = w_en & (~full | ra);

  always_comb begin
    count_nxt = fill_count;
    case ({wa, ra})
      2'b10:   count_nxt = fill_count + CW'(1);
      2'b01:   count_nxt = fill_count - CW'(1);
      default: count_nxt = fill_count;
    endcase
  end

  // Storage is not reset; writes are blocked during the reset cycle.
  always_ff @(posedge clk) begin
    if (rst_n && wa) begin
      mem[wptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fill_count <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      fill_count <= count_nxt;
      data_valid <= ra;
      if (wa) begin
        wptr <= ptr_inc(wptr);
      end
      if (ra) begin
        data_out <= mem[rptr];
        rptr     <= ptr_inc(rptr);
      end
      // A new error in the same cycle as the clear wins.
      overflow  <= (overflow  & ~err_clr) | (w_en & ~wa);
      underflow <= (underflow & ~err_clr) | (r_en & ~ra);
    end
  end

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Bench for sync_fifo_flagged: directed scenarios plus random traffic,
// each cycle compared against a queue-based reference model.
module tb_sync_fifo_flagged;

  localparam int unsigned W   = 32;
  localparam int unsigned D   = 8;
  localparam int unsigned AF  = 6;
  localparam int unsigned AE  = 2;
  localparam int unsigned CWB = $clog2(D + 1);

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   data_in;
  logic           w_en;
  logic           r_en;
  logic           err_clr;
  logic [W-1:0]   data_out;
  logic           data_valid;
  logic           empty;
  logic           full;
  logic           almost_empty;
  logic           almost_full;
  logic [CWB-1:0] fill_count;
  logic           overflow;
  logic           underflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] m_dout;
  bit           m_valid;
  bit           m_ovf;
  bit           m_unf;

  sync_fifo_flagged #(
    .FIFO_WIDTH(W),
    .FIFO_DEPTH(D),
    .AF_TH     (AF),
    .AE_TH     (AE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .w_en        (w_en),
    .r_en        (r_en),
    .err_clr     (err_clr),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .fill_count  (fill_count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: occupancy is simply the queue size.
  task automatic model_cycle(input bit w, input bit r, input logic [W-1:0] d,
                             input bit clr, input bit rst);
    bit m_full;
    bit m_empty;
    bit acc_r;
    bit acc_w;
    if (!rst) begin
      q.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      m_full  = (q.size() == D);
      m_empty = (q.size() == 0);
      acc_r   = r && !m_empty;
      acc_w   = w && (!m_full || acc_r);
      m_valid = acc_r;
      if (acc_r) m_dout = q.pop_front();
      if (acc_w) q.push_back(d);
      m_ovf = (m_ovf && !clr) || (w && !acc_w);
      m_unf = (m_unf && !clr) || (r && !acc_r);
    end
  endtask

  task automatic compare_all();
    int n;
    n = q.size();
    check("fill_count",   32'(fill_count),   32'(n));
    check("empty",        32'(empty),        32'(n == 0));
    check("full",         32'(full),         32'(n == D));
    check("almost_empty", 32'(almost_empty), 32'(n <= AE));
    check("almost_full",  32'(almost_full),  32'(n >= AF));
    check("data_out",     data_out,          m_dout);
    check("data_valid",   32'(data_valid),   32'(m_valid));
    check("overflow",     32'(overflow),     32'(m_ovf));
    check("underflow",    32'(underflow),    32'(m_unf));
  endtask

  // Drive one cycle, advance the model, then sample just after the edge.
  task automatic step(input bit w, input bit r, input logic [W-1:0] d,
                      input bit clr, input bit rst);
    w_en    = w;
    r_en    = r;
    data_in = d;
    err_clr = clr;
    rst_n   = rst;
    model_cycle(w, r, d, clr, rst);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    int wbias;
    int rbias;
    w_en = 0; r_en = 0; data_in = '0; err_clr = 0; rst_n = 0;
    #1;

    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 1);

    // Fill, overflow, drain, underflow
    for (int i = 1; i <= 8; i++) step(1, 0, W'(i * 32'h11), 0, 1);
    step(1, 0, 32'h99, 0, 1);
    for (int i = 0; i < 9; i++) step(0, 1, '0, 0, 1);
    step(0, 0, '0, 1, 1);

    // Full with simultaneous read/write, then drain across wrap
    for (int i = 1; i <= 8; i++) step(1, 0, W'(i * 32'h11), 0, 1);
    for (int i = 0; i < 4; i++) step(1, 1, W'(32'hA0 + i), 0, 1);
    for (int i = 0; i < 8; i++) step(0, 1, '0, 0, 1);
    step(0, 0, '0, 0, 1);

    // Empty with simultaneous read/write: no fall-through
    step(1, 1, 32'h5A, 0, 1);
    step(0, 1, '0, 0, 1);
    step(0, 0, '0, 1, 1);

    // Reset mid-stream discards a concurrent write
    for (int i = 0; i < 5; i++) step(1, 0, W'(32'hC0 + i), 0, 1);
    step(1, 0, 32'hDEAD, 0, 0);
    step(0, 0, '0, 0, 1);

    // Clear coinciding with a rejected write keeps overflow set
    for (int i = 0; i < 8; i++) step(1, 0, W'(32'hE0 + i), 0, 1);
    step(1, 0, 32'hF0, 0, 1);
    step(1, 0, 32'hF1, 1, 1);
    step(0, 0, '0, 1, 1);
    step(0, 0, '0, 0, 0);

    // Random traffic with drifting read/write bias
    wbias = 50;
    rbias = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) begin
        wbias = int'($urandom_range(10, 90));
        rbias = int'($urandom_range(10, 90));
      end
      step(int'($urandom_range(0, 99)) < wbias,
           int'($urandom_range(0, 99)) < rbias,
           W'($urandom()),
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 299) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flagged.md
Name: sync_fifo_flagged

Overview:
- Single-clock, parametrised FIFO; generalises the team's fixed-geometry FIFO in width and depth.
- Adds behaviour the previous generation lacks: programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags with clear, and a read-data valid strobe.
- Sits between producer and consumer logic sharing one clock domain; it is also the reference model target for the FIFO UVM environment.

Parameters:
- FIFO_WIDTH, 32, data word width in bits (>=1).
- FIFO_DEPTH, 16, number of entries (>=2; need not be a power of 2).
- AF_TH, FIFO_DEPTH-2, almost_full asserts when fill_count >= AF_TH (1..FIFO_DEPTH).
- AE_TH, 2, almost_empty asserts when fill_count <= AE_TH (0..FIFO_DEPTH-1).
- CW, $clog2(FIFO_DEPTH+1), width of fill_count (derived; not overridden).

Ports:
- clk  in  1  the only clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk.
- data_in  in  FIFO_WIDTH  write data, sampled when the write is accepted.
- w_en  in  1  write request.
- r_en  in  1  read request.
- err_clr  in  1  clears sticky overflow/underflow.
- data_out  out  FIFO_WIDTH  registered read data.
- data_valid  out  1  high for one cycle when data_out was updated by an accepted read.
- empty  out  1  fill_count == 0.
- full  out  1  fill_count == FIFO_DEPTH.
- almost_empty  out  1  fill_count <= AE_TH.
- almost_full  out  1  fill_count >= AF_TH.
- fill_count  out  CW  current occupancy.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rst_n==0 at posedge): wptr=0, rptr=0, fill_count=0, data_out=0, data_valid=0, overflow=0, underflow=0. Derived flags follow: empty=1, full=0, almost_empty=1, almost_full=0. Memory contents are not reset.
- Reset overrides all requests in the same cycle, including mid-stream. Pending data is discarded and nothing is accepted that cycle.
- All flags are combinational decodes of the fill_count register. They update in the same cycle fill_count updates; there is no extra lag.
- Write accept: wa = w_en & (!full | ra). On accept, mem[wptr] <= data_in. wptr increments and wraps from FIFO_DEPTH-1 to 0.
- Read accept: ra = r_en & !empty. On accept:
  - data_out <= mem[rptr] at the next posedge (latency 1), with data_valid=1 that cycle.
  - rptr increments with the same wrap rule.
- No accepted read: data_out holds its last value and data_valid=0.
- Count update: fill_count <= fill_count + wa - ra.
- Simultaneous read and write when full: both are accepted, count is unchanged, and no overflow is set.
- Simultaneous read and write when empty: the write is accepted and the read is rejected. Underflow is set, count becomes 1, and data_valid stays 0 next cycle. There is no fall-through.
- Rejected write (w_en & full & !ra): memory and wptr are unchanged; overflow <= 1.
- Rejected read (r_en & empty): rptr and data_out are unchanged; underflow <= 1.
- Sticky flags: err_clr clears them next cycle. If a new error occurs in the same cycle as err_clr, set wins.
- Ordering is strict FIFO across pointer wrap-around. A write to the slot being read in the same cycle (full case) returns the old word to data_out.

Test Plan (FIFO_WIDTH=32, FIFO_DEPTH=8, AF_TH=6, AE_TH=2):
- Reset then idle -> empty=1, almost_empty=1, full=0, fill_count=0, data_out=0, overflow=underflow=0.
- Write 0x11..0x88 (8 writes) -> fill_count 1..8; almost_empty drops when count reaches 3; almost_full rises at 6; full=1 at 8. A 9th write of 0x99 -> overflow=1, count stays 8.
- Read 8 times -> data_out 0x11..0x88 in order, each one cycle after its r_en with data_valid=1; empty=1 at end. A 9th read -> underflow=1, data_out stays 0x88, data_valid=0.
- Fill to 8, then assert w_en+r_en for 4 cycles with 0xA0..0xA3 -> count stays 8, reads return 0x11..0x44, no overflow. Drain continues 0x55..0x88 then 0xA0..0xA3, covering pointer wrap.
- Empty FIFO, w_en+r_en with 0x5A -> count=1, underflow=1, data_valid=0. Next cycle r_en -> data_out=0x5A, data_valid=1.
- Count=5, assert rst_n=0 for one cycle with w_en=1 -> count=0, empty=1, write discarded. Separately, assert err_clr in the same cycle as a rejected write -> overflow remains 1.
